// File: rtl/multicycle_controller_if.sv
// rtl/multicycle_controller_if.sv - unified instruction/data memory request bundle
interface multicycle_controller_if;
  logic mem_req;
  logic mem_we;
  logic addr_sel;
  logic mem_ready;

  modport master (output mem_req, output mem_we, output addr_sel, input mem_ready);
  modport slave  (input mem_req, input mem_we, input addr_sel, output mem_ready);
endinterface

// File: rtl/multicycle_controller.sv
// rtl/multicycle_controller.sv - sequencing FSM for the multi-cycle RV32I core
// Steps fetch/decode/execute/memory/writeback and traps on illegal opcodes or memory timeouts.
module multicycle_controller #(
  parameter int MEM_TIMEOUT = 16
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic [6:0]              opcode,
  input  logic [2:0]              funct3,
  input  logic [6:0]              funct7,
  input  logic                    zero,
  multicycle_controller_if.master mem,
  output logic                    ir_we,
  output logic                    pc_we,
  output logic                    pc_src,
  output logic                    rf_we,
  output logic [1:0]              wb_sel,
  output logic [1:0]              alu_src_a,
  output logic [1:0]              alu_src_b,
  output logic [2:0]              imm_sel,
  output logic [3:0]              alu_ctrl,
  output logic                    retire,
  output logic                    halted,
  output logic                    illegal,
  output logic                    bus_err
);

  typedef enum logic [3:0] {
    RST, FETCH, DECODE, EXEC_R, EXEC_I, EXEC_LUI, WB_ALU,
    MEM_ADDR, MEM_RD, WB_MEM, MEM_WR, BRANCH, JAL, TRAP
  } state_t;

  localparam logic [6:0] OP_R   = 7'b0110011;
  localparam logic [6:0] OP_I   = 7'b0010011;
  localparam logic [6:0] OP_LD  = 7'b0000011;
  localparam logic [6:0] OP_ST  = 7'b0100011;
  localparam logic [6:0] OP_BR  = 7'b1100011;
  localparam logic [6:0] OP_JAL = 7'b1101111;
  localparam logic [6:0] OP_LUI = 7'b0110111;

  localparam logic [3:0] ALU_ADD = 4'd0;
  localparam logic [3:0] ALU_SUB = 4'd1;
  localparam logic [3:0] ALU_SLL = 4'd2;
  localparam logic [3:0] ALU_SLT = 4'd3;
  localparam logic [3:0] ALU_XOR = 4'd5;
  localparam logic [3:0] ALU_SRL = 4'd6;
  localparam logic [3:0] ALU_SRA = 4'd7;
  localparam logic [3:0] ALU_OR  = 4'd8;
  localparam logic [3:0] ALU_AND = 4'd9;

  localparam logic [7:0] TIMEOUT = 8'(MEM_TIMEOUT);

  state_t     state_q, state_d;
  logic [7:0] wait_cnt_q, wait_cnt_d;
  logic       illegal_q, illegal_d;
  logic       bus_err_q, bus_err_d;
  logic       mem_req_c, mem_we_c, addr_sel_c;

  // Only funct7[5] distinguishes SUB/SRA in the supported subset.
  logic unused_funct7;
  assign unused_funct7 = ^{funct7[6], funct7[4:0]};

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= RST;
      wait_cnt_q <= '0;
      illegal_q  <= 1'b0;
      bus_err_q  <= 1'b0;
    end else begin
      state_q    <= state_d;
      wait_cnt_q <= wait_cnt_d;
      illegal_q  <= illegal_d;
      bus_err_q  <= bus_err_d;
    end
  end

  always_comb begin
    state_d    = state_q;
    wait_cnt_d = '0;
    illegal_d  = illegal_q;
    bus_err_d  = bus_err_q;
    mem_req_c  = 1'b0;
    mem_we_c   = 1'b0;
    addr_sel_c = 1'b0;
    ir_we      = 1'b0;
    pc_we      = 1'b0;
    pc_src     = 1'b0;
    rf_we      = 1'b0;
    wb_sel     = 2'd0;
    alu_src_a  = 2'd0;
    alu_src_b  = 2'd0;
    imm_sel    = 3'd0;
    alu_ctrl   = ALU_ADD;
    retire     = 1'b0;

    case (state_q)
      RST: state_d = FETCH;
      FETCH: begin
        mem_req_c = 1'b1;
        alu_src_b = 2'd2;
        if (mem.mem_ready) begin
          ir_we   = 1'b1;
          pc_we   = 1'b1;
          state_d = DECODE;
        end
      end
      DECODE: begin
        alu_src_a = 2'd2;
        alu_src_b = 2'd1;
        imm_sel   = (opcode == OP_JAL) ? 3'd4 : 3'd2;
        case (opcode)
          OP_R:         state_d = EXEC_R;
          OP_I:         state_d = EXEC_I;
          OP_LD, OP_ST: state_d = MEM_ADDR;
          OP_BR:        state_d = BRANCH;
          OP_JAL:       state_d = JAL;
          OP_LUI:       state_d = EXEC_LUI;
          default: begin
            state_d   = TRAP;
            illegal_d = 1'b1;
          end
        endcase
      end
      EXEC_R: begin
        alu_src_a = 2'd1;
        state_d   = WB_ALU;
        case (funct3)
          3'b000:  alu_ctrl = funct7[5] ? ALU_SUB : ALU_ADD;
          3'b001:  alu_ctrl = ALU_SLL;
          3'b010:  alu_ctrl = ALU_SLT;
          3'b100:  alu_ctrl = ALU_XOR;
          3'b101:  alu_ctrl = funct7[5] ? ALU_SRA : ALU_SRL;
          3'b110:  alu_ctrl = ALU_OR;
          3'b111:  alu_ctrl = ALU_AND;
          default: alu_ctrl = ALU_ADD;
        endcase
      end
      EXEC_I: begin
        alu_src_a = 2'd1;
        alu_src_b = 2'd1;
        state_d   = WB_ALU;
        case (funct3)
          3'b010: alu_ctrl = ALU_SLT;
          3'b100: alu_ctrl = ALU_XOR;
          3'b110: alu_ctrl = ALU_OR;
          3'b111: alu_ctrl = ALU_AND;
          // Immediate shifts are outside the supported subset.
          3'b001, 3'b101: begin
            state_d   = TRAP;
            illegal_d = 1'b1;
          end
          default: alu_ctrl = ALU_ADD;
        endcase
      end
      EXEC_LUI: begin
        alu_src_a = 2'd3;
        alu_src_b = 2'd1;
        imm_sel   = 3'd3;
        state_d   = WB_ALU;
      end
      WB_ALU: begin
        rf_we   = 1'b1;
        retire  = 1'b1;
        state_d = FETCH;
      end
      MEM_ADDR: begin
        alu_src_a = 2'd1;
        alu_src_b = 2'd1;
        imm_sel   = (opcode == OP_ST) ? 3'd1 : 3'd0;
        state_d   = (opcode == OP_ST) ? MEM_WR : MEM_RD;
      end
      MEM_RD: begin
        mem_req_c  = 1'b1;
        addr_sel_c = 1'b1;
        if (mem.mem_ready) state_d = WB_MEM;
      end
      WB_MEM: begin
        rf_we   = 1'b1;
        wb_sel  = 2'd1;
        retire  = 1'b1;
        state_d = FETCH;
      end
      MEM_WR: begin
        mem_req_c  = 1'b1;
        mem_we_c   = 1'b1;
        addr_sel_c = 1'b1;
        if (mem.mem_ready) begin
          retire  = 1'b1;
          state_d = FETCH;
        end
      end
      BRANCH: begin
        alu_src_a = 2'd1;
        alu_ctrl  = ALU_SUB;
        pc_src    = 1'b1;
        state_d   = FETCH;
        case (funct3)
          3'b000: begin
            pc_we  = zero;
            retire = 1'b1;
          end
          3'b001: begin
            pc_we  = !zero;
            retire = 1'b1;
          end
          default: begin
            state_d   = TRAP;
            illegal_d = 1'b1;
          end
        endcase
      end
      JAL: begin
        pc_we   = 1'b1;
        pc_src  = 1'b1;
        rf_we   = 1'b1;
        wb_sel  = 2'd2;
        retire  = 1'b1;
        state_d = FETCH;
      end
      TRAP: state_d = TRAP;
      default: state_d = RST;
    endcase

    // Timeout shares one counter across all memory-wait states; mem_ready wins on the limit cycle.
    if (mem_req_c && !mem.mem_ready) begin
      wait_cnt_d = wait_cnt_q + 8'd1;
      if (wait_cnt_d == TIMEOUT) begin
        state_d    = TRAP;
        bus_err_d  = 1'b1;
        wait_cnt_d = '0;
      end
    end
  end

  assign mem.mem_req  = mem_req_c;
  assign mem.mem_we   = mem_we_c;
  assign mem.addr_sel = addr_sel_c;
  assign halted       = (state_q == TRAP);
  assign illegal      = illegal_q;
  assign bus_err      = bus_err_q;

endmodule

// File: tb/tb_multicycle_controller.sv
// tb/tb_multicycle_controller.sv - directed vector bench for multicycle_controller
module tb_multicycle_controller;

  typedef struct packed {
    logic       mem_req;
    logic       mem_we;
    logic       addr_sel;
    logic       ir_we;
    logic       pc_we;
    logic       pc_src;
    logic       rf_we;
    logic [1:0] wb_sel;
    logic [1:0] alu_src_a;
    logic [1:0] alu_src_b;
    logic [2:0] imm_sel;
    logic [3:0] alu_ctrl;
    logic       retire;
    logic       halted;
    logic       illegal;
    logic       bus_err;
  } outs_t;

  typedef struct {
    logic       rst;
    logic [6:0] op;
    logic [2:0] f3;
    logic [6:0] f7;
    logic       z;
    logic       rdy;
    outs_t      exp;
    outs_t      care;
    string      name;
  } vec_t;

  localparam logic [6:0] OP_R   = 7'b0110011;
  localparam logic [6:0] OP_I   = 7'b0010011;
  localparam logic [6:0] OP_LD  = 7'b0000011;
  localparam logic [6:0] OP_ST  = 7'b0100011;
  localparam logic [6:0] OP_BR  = 7'b1100011;
  localparam logic [6:0] OP_JAL = 7'b1101111;
  localparam logic [6:0] OP_LUI = 7'b0110111;
  localparam logic [6:0] F7S    = 7'b0100000;

  logic       clk = 1'b0;
  logic       rst_n;
  logic [6:0] opcode;
  logic [2:0] funct3;
  logic [6:0] funct7;
  logic       zero;
  logic       ir_we, pc_we, pc_src, rf_we, retire, halted, illegal, bus_err;
  logic [1:0] wb_sel, alu_src_a, alu_src_b;
  logic [2:0] imm_sel;
  logic [3:0] alu_ctrl;

  int total = 0;
  int bad   = 0;

  multicycle_controller_if mif ();

  multicycle_controller #(.MEM_TIMEOUT(16)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .opcode    (opcode),
    .funct3    (funct3),
    .funct7    (funct7),
    .zero      (zero),
    .mem       (mif.master),
    .ir_we     (ir_we),
    .pc_we     (pc_we),
    .pc_src    (pc_src),
    .rf_we     (rf_we),
    .wb_sel    (wb_sel),
    .alu_src_a (alu_src_a),
    .alu_src_b (alu_src_b),
    .imm_sel   (imm_sel),
    .alu_ctrl  (alu_ctrl),
    .retire    (retire),
    .halted    (halted),
    .illegal   (illegal),
    .bus_err   (bus_err)
  );

  always #5 clk = ~clk;

  function automatic outs_t o(input int req, we, as, irwe, pcwe, pcsrc, rfwe,
                              input int wb, a, b, imm, alu, ret, hlt, ill, berr);
    return {1'(req), 1'(we), 1'(as), 1'(irwe), 1'(pcwe), 1'(pcsrc), 1'(rfwe),
            2'(wb), 2'(a), 2'(b), 3'(imm), 4'(alu), 1'(ret), 1'(hlt), 1'(ill), 1'(berr)};
  endfunction

  function automatic vec_t v(input int rst, input logic [6:0] op, input int f3, input logic [6:0] f7,
                             input int z, input int rdy, input outs_t e, input string n);
    vec_t r;
    r.rst = 1'(rst); r.op = op; r.f3 = 3'(f3); r.f7 = f7; r.z = 1'(z); r.rdy = 1'(rdy);
    r.exp = e; r.care = '1; r.name = n;
    return r;
  endfunction

  function automatic outs_t exec_r(input int alu);
    return o(0,0,0,0,0,0,0, 0,1,0,0,alu, 0,0,0,0);
  endfunction

  function automatic outs_t exec_i(input int alu);
    return o(0,0,0,0,0,0,0, 0,1,1,0,alu, 0,0,0,0);
  endfunction

  outs_t E_Z, E_F1, E_F0, E_DEC, E_DECJ, E_WBA, E_LUI, E_MAL, E_MAS, E_MRD, E_WBM;
  outs_t E_MWR1, E_MWR0, E_BRT, E_BRN, E_BRX, E_JAL, E_TRI, E_TRB;
  vec_t  vq[$];

  task automatic check(input string name, input outs_t e, input outs_t care);
    outs_t got;
    got = {mif.mem_req, mif.mem_we, mif.addr_sel, ir_we, pc_we, pc_src, rf_we,
           wb_sel, alu_src_a, alu_src_b, imm_sel, alu_ctrl, retire, halted, illegal, bus_err};
    total++;
    if (((got ^ e) & care) != '0) begin
      bad++;
      $display("FAIL %s: got=%h expected=%h care=%h", name, got, e, care);
    end
  endtask

  task automatic run_row(input vec_t r);
    @(negedge clk);
    rst_n         = r.rst;
    opcode        = r.op;
    funct3        = r.f3;
    funct7        = r.f7;
    zero          = r.z;
    mif.mem_ready = r.rdy;
    #1;
    check(r.name, r.exp, r.care);
  endtask

  task automatic push_alu(input logic [6:0] op, input int f3, input logic [6:0] f7,
                          input outs_t ex, input string n);
    vq.push_back(v(1, op, f3, f7, 0, 1, E_F1, {n, "_fetch"}));
    vq.push_back(v(1, op, f3, f7, 0, 1, E_DEC, {n, "_decode"}));
    vq.push_back(v(1, op, f3, f7, 0, 1, ex, {n, "_exec"}));
    vq.push_back(v(1, op, f3, f7, 0, 1, E_WBA, {n, "_wb"}));
  endtask

  task automatic push_reset(input string n);
    vq.push_back(v(0, OP_R, 0, 0, 0, 1, E_Z, {n, "_rst_low"}));
    vq.push_back(v(1, OP_R, 0, 0, 0, 1, E_Z, {n, "_rst_state"}));
  endtask

  initial begin
    vec_t r;
    rst_n = 1'b0; opcode = '0; funct3 = '0; funct7 = '0; zero = 1'b0; mif.mem_ready = 1'b0;

    E_Z    = '0;
    E_F1   = o(1,0,0,1,1,0,0, 0,0,2,0,0, 0,0,0,0);
    E_F0   = o(1,0,0,0,0,0,0, 0,0,2,0,0, 0,0,0,0);
    E_DEC  = o(0,0,0,0,0,0,0, 0,2,1,2,0, 0,0,0,0);
    E_DECJ = o(0,0,0,0,0,0,0, 0,2,1,4,0, 0,0,0,0);
    E_WBA  = o(0,0,0,0,0,0,1, 0,0,0,0,0, 1,0,0,0);
    E_LUI  = o(0,0,0,0,0,0,0, 0,3,1,3,0, 0,0,0,0);
    E_MAL  = o(0,0,0,0,0,0,0, 0,1,1,0,0, 0,0,0,0);
    E_MAS  = o(0,0,0,0,0,0,0, 0,1,1,1,0, 0,0,0,0);
    E_MRD  = o(1,0,1,0,0,0,0, 0,0,0,0,0, 0,0,0,0);
    E_WBM  = o(0,0,0,0,0,0,1, 1,0,0,0,0, 1,0,0,0);
    E_MWR1 = o(1,1,1,0,0,0,0, 0,0,0,0,0, 1,0,0,0);
    E_MWR0 = o(1,1,1,0,0,0,0, 0,0,0,0,0, 0,0,0,0);
    E_BRT  = o(0,0,0,0,1,1,0, 0,1,0,0,1, 1,0,0,0);
    E_BRN  = o(0,0,0,0,0,1,0, 0,1,0,0,1, 1,0,0,0);
    E_BRX  = o(0,0,0,0,0,1,0, 0,1,0,0,1, 0,0,0,0);
    E_JAL  = o(0,0,0,0,1,1,1, 2,0,0,0,0, 1,0,0,0);
    E_TRI  = o(0,0,0,0,0,0,0, 0,0,0,0,0, 0,1,1,0);
    E_TRB  = o(0,0,0,0,0,0,0, 0,0,0,0,0, 0,1,0,1);

    push_reset("init");
    push_alu(OP_R,   0, 7'd0, exec_r(0), "add");
    push_alu(OP_R,   0, F7S,  exec_r(1), "sub");
    push_alu(OP_R,   5, F7S,  exec_r(7), "sra");
    push_alu(OP_R,   7, 7'd0, exec_r(9), "and");
    push_alu(OP_I,   6, 7'd0, exec_i(8), "ori");
    push_alu(OP_I,   2, 7'd0, exec_i(3), "slti");
    push_alu(OP_LUI, 0, 7'd0, E_LUI,     "lui");

    vq.push_back(v(1, OP_LD, 2, 0, 0, 1, E_F1,  "lw_fetch"));
    vq.push_back(v(1, OP_LD, 2, 0, 0, 1, E_DEC, "lw_decode"));
    vq.push_back(v(1, OP_LD, 2, 0, 0, 1, E_MAL, "lw_addr"));
    for (int i = 0; i < 3; i++) vq.push_back(v(1, OP_LD, 2, 0, 0, 0, E_MRD, "lw_rd_wait"));
    vq.push_back(v(1, OP_LD, 2, 0, 0, 1, E_MRD, "lw_rd_done"));
    vq.push_back(v(1, OP_LD, 2, 0, 0, 1, E_WBM, "lw_wb"));
    vq.push_back(v(1, OP_R,  0, 0, 0, 0, E_F0,  "lw_next_fetch"));
    vq.push_back(v(1, OP_ST, 2, 0, 0, 1, E_F1,  "sw_fetch"));
    vq.push_back(v(1, OP_ST, 2, 0, 0, 1, E_DEC, "sw_decode"));
    vq.push_back(v(1, OP_ST, 2, 0, 0, 1, E_MAS, "sw_addr"));
    vq.push_back(v(1, OP_ST, 2, 0, 0, 1, E_MWR1, "sw_wr"));
    vq.push_back(v(1, OP_BR, 0, 0, 1, 1, E_F1,  "beq_fetch"));
    vq.push_back(v(1, OP_BR, 0, 0, 1, 1, E_DEC, "beq_decode"));
    vq.push_back(v(1, OP_BR, 0, 0, 1, 1, E_BRT, "beq_taken"));
    vq.push_back(v(1, OP_BR, 1, 0, 1, 1, E_F1,  "bne_fetch"));
    vq.push_back(v(1, OP_BR, 1, 0, 1, 1, E_DEC, "bne_decode"));
    vq.push_back(v(1, OP_BR, 1, 0, 1, 1, E_BRN, "bne_not_taken"));
    vq.push_back(v(1, OP_BR, 1, 0, 0, 1, E_F1,  "bne2_fetch"));
    vq.push_back(v(1, OP_BR, 1, 0, 0, 1, E_DEC, "bne2_decode"));
    vq.push_back(v(1, OP_BR, 1, 0, 0, 1, E_BRT, "bne_taken"));
    vq.push_back(v(1, OP_JAL, 0, 0, 0, 1, E_F1,   "jal_fetch"));
    vq.push_back(v(1, OP_JAL, 0, 0, 0, 1, E_DECJ, "jal_decode"));
    vq.push_back(v(1, OP_JAL, 0, 0, 0, 1, E_JAL,  "jal_exec"));
    vq.push_back(v(1, OP_I, 5, 0, 0, 1, E_F1,  "srli_fetch"));
    vq.push_back(v(1, OP_I, 5, 0, 0, 1, E_DEC, "srli_decode"));
    r = v(1, OP_I, 5, 0, 0, 1, exec_i(0), "srli_exec");
    r.care.alu_ctrl = '0;
    vq.push_back(r);
    vq.push_back(v(1, OP_I, 5, 0, 0, 1, E_TRI, "srli_trap"));
    vq.push_back(v(1, OP_R, 0, 0, 0, 1, E_TRI, "trap_absorb"));
    push_reset("ill");
    vq.push_back(v(1, 7'b1111111, 0, 0, 0, 1, E_F1,  "badop_fetch"));
    vq.push_back(v(1, 7'b1111111, 0, 0, 0, 1, E_DEC, "badop_decode"));
    vq.push_back(v(1, 7'b1111111, 0, 0, 0, 1, E_TRI, "badop_trap"));
    push_reset("blt");
    vq.push_back(v(1, OP_BR, 4, 0, 1, 1, E_F1,  "blt_fetch"));
    vq.push_back(v(1, OP_BR, 4, 0, 1, 1, E_DEC, "blt_decode"));
    vq.push_back(v(1, OP_BR, 4, 0, 1, 1, E_BRX, "blt_branch"));
    vq.push_back(v(1, OP_BR, 4, 0, 1, 1, E_TRI, "blt_trap"));

    foreach (vq[i]) run_row(vq[i]);

    // Fetch timeout: 16 waiting cycles, then TRAP with bus_err.
    run_row(v(0, OP_R, 0, 0, 0, 0, E_Z, "to_rst_low"));
    run_row(v(1, OP_R, 0, 0, 0, 0, E_Z, "to_rst_state"));
    for (int i = 0; i < 16; i++) run_row(v(1, OP_R, 0, 0, 0, 0, E_F0, "to_wait"));
    run_row(v(1, OP_R, 0, 0, 0, 0, E_TRB, "to_trap"));
    run_row(v(1, OP_R, 0, 0, 0, 1, E_TRB, "to_absorb"));

    // mem_ready on the 16th wait cycle completes the fetch without a trap.
    run_row(v(0, OP_R, 0, 0, 0, 0, E_Z, "edge_rst_low"));
    run_row(v(1, OP_R, 0, 0, 0, 0, E_Z, "edge_rst_state"));
    for (int i = 0; i < 15; i++) run_row(v(1, OP_R, 0, 0, 0, 0, E_F0, "edge_wait"));
    run_row(v(1, OP_R, 0, 0, 0, 1, E_F1, "edge_ready"));
    run_row(v(1, OP_R, 0, 0, 0, 1, E_DEC, "edge_decode"));

    // Reset pulled mid-store drops the strobes without a clock edge.
    run_row(v(0, OP_ST, 0, 0, 0, 1, E_Z, "swr_rst_low"));
    run_row(v(1, OP_ST, 0, 0, 0, 1, E_Z, "swr_rst_state"));
    run_row(v(1, OP_ST, 0, 0, 0, 1, E_F1, "swr_fetch"));
    run_row(v(1, OP_ST, 0, 0, 0, 1, E_DEC, "swr_decode"));
    run_row(v(1, OP_ST, 0, 0, 0, 1, E_MAS, "swr_addr"));
    run_row(v(1, OP_ST, 0, 0, 0, 0, E_MWR0, "swr_wait"));
    #2;
    rst_n = 1'b0;
    #1;
    check("swr_async_drop", E_Z, '1);
    run_row(v(0, OP_R, 0, 0, 0, 1, E_Z, "swr_hold"));
    run_row(v(1, OP_R, 0, 0, 0, 1, E_Z, "swr_release"));
    run_row(v(1, OP_R, 0, 0, 0, 1, E_F1, "swr_restart_fetch"));

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/multicycle_controller.md
Name: multicycle_controller

Overview:
- Sequencing FSM for the multi-cycle RV32I core variant: one shared ALU, one unified instruction/data memory port, and the datapath registers IR, PC, OLDPC, A, B, ALUOut and MDR.
- Decodes opcode/funct from IR, steps the datapath through fetch/decode/execute/memory/writeback, and handshakes with memory.
- Traps on illegal opcodes and on memory timeouts.
- Supports the instruction subset R-type, OP-IMM, LOAD, STORE, BEQ/BNE, JAL and LUI.

Parameters:
- MEM_TIMEOUT, 16, maximum wait cycles for mem_ready in any memory state before bus error (1..255).

Ports:
- clk  in  1  system clock
- rst_n  in  1  reset, asynchronous, active-low
- opcode  in  7  IR[6:0], valid from DECODE onward
- funct3  in  3  IR[14:12]
- funct7  in  7  IR[31:25]
- zero  in  1  ALU zero flag
- mem_ready  in  1  memory completes the current request this cycle
- mem_req  out  1  memory request valid
- mem_we  out  1  request is a write
- addr_sel  out  1  memory address: 0=PC, 1=ALUOut
- ir_we  out  1  load IR (and OLDPC) from memory/PC
- pc_we  out  1  load PC
- pc_src  out  1  PC input: 0=ALU result, 1=ALUOut
- rf_we  out  1  register file write
- wb_sel  out  2  writeback: 0=ALUOut, 1=MDR, 2=PC
- alu_src_a  out  2  0=PC, 1=A, 2=OLDPC, 3=zero
- alu_src_b  out  2  0=B, 1=imm, 2=constant 4
- imm_sel  out  3  0=I, 1=S, 2=B, 3=U, 4=J
- alu_ctrl  out  4  0 add, 1 sub, 2 sll, 3 slt, 5 xor, 6 srl, 7 sra, 8 or, 9 and
- retire  out  1  one-cycle pulse per completed instruction
- halted  out  1  in TRAP state
- illegal  out  1  sticky: trap cause is illegal instruction
- bus_err  out  1  sticky: trap cause is memory timeout

Behaviour:
- Clock and reset: one clock, clk. Reset rst_n is asynchronous and active-low.
- While rst_n is low: state=RST, wait counter=0, and every output is 0.
- Moore outputs are decoded from the state register and opcode/funct3. In FETCH, ir_we and pc_we are Mealy, gated by mem_ready. In BRANCH, pc_we is gated by zero.
- All control outputs default to 0 outside the states listed below.
- RST -> FETCH unconditionally on the first clock after reset release.
- FETCH: mem_req=1, addr_sel=0, alu_src_a=0, alu_src_b=2, alu_ctrl=0. On mem_ready: ir_we=1, pc_we=1, pc_src=0, next state DECODE.
- DECODE: ALUOut<=OLDPC+imm, using alu_src_a=2, alu_src_b=1, alu_ctrl=0. imm_sel=4 for JAL, otherwise 2. Next state by opcode:
  - 0110011 -> EXEC_R
  - 0010011 -> EXEC_I
  - 0000011 and 0100011 -> MEM_ADDR
  - 1100011 -> BRANCH
  - 1101111 -> JAL
  - 0110111 -> EXEC_LUI
  - anything else -> TRAP, with illegal<=1
- EXEC_R: alu_src_a=1, alu_src_b=0. alu_ctrl by funct3:
  - 000 -> sub if funct7[5], else add
  - 001 -> sll
  - 010 -> slt
  - 100 -> xor
  - 101 -> sra if funct7[5], else srl
  - 110 -> or
  - 111 -> and
  - Next state WB_ALU.
- EXEC_I: alu_src_a=1, alu_src_b=1, imm_sel=0. funct3 mapping: 000 add, 010 slt, 100 xor, 110 or, 111 and. funct3 001/101 -> TRAP, with illegal. Otherwise next state WB_ALU.
- EXEC_LUI: alu_src_a=3, alu_src_b=1, imm_sel=3, alu_ctrl=0. Next state WB_ALU.
- WB_ALU: rf_we=1, wb_sel=0, retire=1. Next state FETCH.
- MEM_ADDR: alu_src_a=1, alu_src_b=1, alu_ctrl=0. imm_sel=1 for store, 0 for load. Next state MEM_WR for store, MEM_RD for load.
- MEM_RD: mem_req=1, addr_sel=1. On mem_ready -> WB_MEM; MDR captures unconditionally.
- WB_MEM: rf_we=1, wb_sel=1, retire=1. Next state FETCH.
- MEM_WR: mem_req=1, mem_we=1, addr_sel=1. On mem_ready: retire=1, next state FETCH.
- BRANCH: alu_src_a=1, alu_src_b=0, alu_ctrl=1, pc_src=1, retire=1.
  - pc_we = zero for funct3=000 (BEQ); pc_we = !zero for funct3=001 (BNE).
  - Other funct3 -> TRAP, with illegal, no retire.
  - Next state FETCH.
- JAL: pc_we=1, pc_src=1, rf_we=1, wb_sel=2 (PC already holds OLDPC+4), retire=1. Next state FETCH.
- Cycle counts with zero memory wait: R/I/LUI 4, load 5, store 4, branch 3, JAL 3.
- Wait counter:
  - Cleared on entry to FETCH/MEM_RD/MEM_WR and on mem_ready.
  - Increments each cycle the state is waiting with mem_ready=0.
  - Reaching MEM_TIMEOUT with mem_ready=0 -> TRAP, bus_err<=1, mem_req drops the next cycle.
  - mem_ready in the same cycle the count hits the limit: the transfer completes and no trap is taken.
- mem_req stays asserted and address/we stay stable until mem_ready or timeout.
- TRAP: halted=1, all strobes 0. Absorbing until rst_n is low; illegal/bus_err hold their values.
- Reset asserted mid-instruction: the controller returns to RST immediately and all strobes drop asynchronously.

Test Plan:
- Reset release with mem_ready=1 and IR=ADD (0110011/000/0000000) -> RST, FETCH, DECODE, EXEC_R (alu_ctrl=0), WB_ALU (rf_we=1, retire=1); next FETCH in cycle 5.
- SUB then SRA (funct7=0100000, funct3 000/101) -> alu_ctrl 1 and 7 in EXEC_R. SRLI (OP-IMM funct3=101) -> halted=1, illegal=1.
- LW with mem_ready low for 3 cycles in MEM_RD -> mem_req/addr_sel=1 held 4 cycles, then WB_MEM with wb_sel=1; total 8 cycles.
- BEQ with zero=1 -> pc_we=1, pc_src=1 in BRANCH. BNE with zero=1 -> pc_we=0. Both retire once.
- JAL -> DECODE imm_sel=4; JAL state pc_we=1, rf_we=1, wb_sel=2.
- mem_ready held 0 in FETCH with MEM_TIMEOUT=16 -> TRAP after 16 wait cycles, bus_err=1, mem_req=0. rst_n pulse low mid-MEM_WR -> mem_we drops immediately, and the controller restarts at FETCH after reset release.
